// File: rtl/pb_debounce_pkg.sv
// Shared definitions for push-button conditioners: FSM state encoding and
// the legal range of the debounce length.
package pb_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam int unsigned DEBOUNCE_MIN = 1;
  localparam int unsigned DEBOUNCE_MAX = 65535;

  function automatic bit debounce_cycles_legal(input int unsigned n);
    return (n >= DEBOUNCE_MIN) && (n <= DEBOUNCE_MAX);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level; both flops clear on
// reset so a held input is seen as a fresh edge once reset releases.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // NOTE: flops use non-blocking assignments so s2 takes the old s1, giving two real stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pb_debounce_toggle.sv
// Push-button conditioner: synchronise, debounce, emit one T pulse per clean
// press and hold the resulting toggle state for the LED outputs.
module pb_debounce_toggle
  import pb_debounce_pkg::*;
#(
  parameter  int unsigned DEBOUNCE_CYCLES = 4,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button_level,
  output logic t_pulse,
  output logic q,
  output logic q_n
);

  if (!debounce_cycles_legal(DEBOUNCE_CYCLES)) begin : g_bad_debounce
    $error("pb_debounce_toggle: DEBOUNCE_CYCLES must be within 1..65535");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s2;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             toggle_q, toggle_d;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d_i (button_raw),
    .q_o (s2)
  );

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    toggle_d = toggle_q;
    unique case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          pulse_d  = 1'b1;
          toggle_d = ~toggle_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A release never pulses; a re-press simply restores PRESSED.
        if (s2) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      toggle_q <= toggle_d;
    end
  end

  assign button_level = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign t_pulse      = pulse_q;
  assign q            = toggle_q;
  assign q_n          = ~toggle_q;

endmodule

// File: tb/tb_pb_debounce_toggle.sv
// Bench for pb_debounce_toggle at DEBOUNCE_CYCLES=4 and =1: expected pulses
// (cycle and new q) are queued by the stimulus and matched by a monitor.
module tb_pb_debounce_toggle;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic lvl_a, t_a, q_a, q_n_a;
  logic lvl_b, t_b, q_b, q_n_b;

  pb_debounce_toggle #(.DEBOUNCE_CYCLES(4)) dut_a (
    .clk          (clk),
    .rst          (rst),
    .button_raw   (raw_a),
    .button_level (lvl_a),
    .t_pulse      (t_a),
    .q            (q_a),
    .q_n          (q_n_a)
  );

  pb_debounce_toggle #(.DEBOUNCE_CYCLES(1)) dut_b (
    .clk          (clk),
    .rst          (rst),
    .button_raw   (raw_b),
    .button_level (lvl_b),
    .t_pulse      (t_b),
    .q            (q_b),
    .q_n          (q_n_b)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   cyc;
    logic q;
  } pulse_t;

  pulse_t exp_a[$];
  pulse_t exp_b[$];
  logic   q_model_a = 1'b0;
  logic   q_model_b = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw goes high now (after edge c); first sampling edge is c+1, pulse lands at c+1+2+N.
  task automatic expect_press(input bit on_b, input int n_deb);
    pulse_t p;
    p.cyc = cyc + 3 + n_deb;
    if (on_b) begin
      q_model_b = ~q_model_b;
      p.q       = q_model_b;
      exp_b.push_back(p);
    end else begin
      q_model_a = ~q_model_a;
      p.q       = q_model_a;
      exp_a.push_back(p);
    end
  endtask

  logic inv_a, inv_b;

  always @(negedge clk) begin
    pulse_t p;
    if (t_a) begin
      if (exp_a.size() == 0) begin
        check("unexpected_pulse_a", int'(t_a), 0);
      end else begin
        p = exp_a.pop_front();
        check("pulse_cycle_a", cyc, p.cyc);
        check("pulse_q_a", int'(q_a), int'(p.q));
        check("pulse_level_a", int'(lvl_a), 1);
      end
    end
    if (t_b) begin
      if (exp_b.size() == 0) begin
        check("unexpected_pulse_b", int'(t_b), 0);
      end else begin
        p = exp_b.pop_front();
        check("pulse_cycle_b", cyc, p.cyc);
        check("pulse_q_b", int'(q_b), int'(p.q));
        check("pulse_level_b", int'(lvl_b), 1);
      end
    end
    inv_a = ~q_a;
    inv_b = ~q_b;
    check("qn_a", int'(q_n_a), int'(inv_a));
    check("qn_b", int'(q_n_b), int'(inv_b));
  end

  initial begin
    logic [4:0] bounce;

    // Reset held two cycles with the button pressed.
    rst   = 1'b1;
    raw_a = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_q_a", int'(q_a), 0);
    check("rst_qn_a", int'(q_n_a), 1);
    check("rst_pulse_a", int'(t_a), 0);
    check("rst_level_a", int'(lvl_a), 0);
    check("rst_q_b", int'(q_b), 0);
    tick(1);
    rst = 1'b0;
    expect_press(1'b0, 4);
    tick(12);
    check("held_level_a", int'(lvl_a), 1);
    raw_a = 1'b0;
    tick(12);
    check("released_level_a", int'(lvl_a), 0);

    // Two clean presses: q goes 1->0->1, no pulse on release.
    for (int i = 0; i < 2; i++) begin
      raw_a = 1'b1;
      expect_press(1'b0, 4);
      tick(20);
      check("clean_level_hi_a", int'(lvl_a), 1);
      raw_a = 1'b0;
      tick(10);
      check("clean_level_lo_a", int'(lvl_a), 0);
      check("clean_q_a", int'(q_a), int'(q_model_a));
    end

    // Bounce 1,0,1,0,1 then stable high: one pulse keyed to the last rise.
    bounce = 5'b10101;
    for (int i = 4; i >= 0; i--) begin
      raw_a = bounce[i];
      if (i == 0) expect_press(1'b0, 4);
      else tick(1);
    end
    tick(14);
    check("bounce_q_a", int'(q_a), int'(q_model_a));
    raw_a = 1'b0;
    tick(10);

    // Release bounce while PRESSED: short drop must not reach IDLE.
    raw_a = 1'b1;
    expect_press(1'b0, 4);
    tick(10);
    raw_a = 1'b0;
    tick(2);
    raw_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("relbounce_level_a", int'(lvl_a), 1);
      check("relbounce_q_a", int'(q_a), int'(q_model_a));
      tick(1);
    end
    raw_a = 1'b0;
    tick(10);
    check("relbounce_final_level_a", int'(lvl_a), 0);

    // Reset at edge k+4 of a press: aborted, q cleared.
    raw_a = 1'b1;
    tick(4);
    rst       = 1'b1;
    raw_a     = 1'b0;
    q_model_a = 1'b0;
    q_model_b = 1'b0;
    tick(1);
    check("midrst_level_a", int'(lvl_a), 0);
    check("midrst_pulse_a", int'(t_a), 0);
    check("midrst_q_a", int'(q_a), 0);
    rst = 1'b0;
    tick(12);
    check("midrst_after_q_a", int'(q_a), 0);
    check("midrst_after_level_a", int'(lvl_a), 0);

    // DEBOUNCE_CYCLES=1: single-sample glitch ignored, press pulses at k+3.
    raw_b = 1'b1;
    tick(1);
    raw_b = 1'b0;
    tick(6);
    check("glitch_q_b", int'(q_b), 0);
    for (int i = 0; i < 2; i++) begin
      raw_b = 1'b1;
      expect_press(1'b1, 1);
      tick(5);
      check("press_level_b", int'(lvl_b), 1);
      raw_b = 1'b0;
      tick(5);
      check("release_level_b", int'(lvl_b), 0);
      check("press_q_b", int'(q_b), int'(q_model_b));
    end

    tick(5);
    check("missing_pulses_a", exp_a.size(), 0);
    check("missing_pulses_b", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pb_debounce_toggle.md
# pb_debounce_toggle

Input-side conditioner that produces the toggle stimulus consumed by the T flip-flop circuits. It takes a raw, bouncing, asynchronous push-button level, synchronises and debounces it, emits exactly one single-cycle T pulse per clean press, and keeps the resulting toggle state (Q / not-Q) for the LED outputs. It sits between the board push-button pin and any toggle or LED logic.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive synchronised samples required to accept a level change; legal range 1..65535; 0 is illegal (elaboration error).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): counter width; derived, not overridden.
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- button_raw  input  1  asynchronous, bouncing push-button level (1 = pressed).
- button_level  output  1  debounced button level (1 in PRESSED/RELEASE_WAIT).
- t_pulse  output  1  one-cycle strobe per accepted press.
- q  output  1  toggle state; inverts on every t_pulse.
- q_n  output  1  always ~q.

## Operation
- Two-flop synchroniser: button_raw -> s1 -> s2; FSM uses s2 only.
- States: IDLE (released, stable), PRESS_WAIT, PRESSED (held, stable), RELEASE_WAIT.
- IDLE: s2=1 -> PRESS_WAIT, cnt<=0; else stay.
- PRESS_WAIT: s2=0 -> IDLE, cnt<=0, no pulse. s2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, t_pulse<=1, q<=~q. Otherwise cnt<=cnt+1.
- PRESSED: s2=0 -> RELEASE_WAIT, cnt<=0; else stay.
- RELEASE_WAIT: s2=1 -> PRESSED, cnt<=0, no pulse. s2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt<=cnt+1.
- Release never produces a pulse; only IDLE->PRESS_WAIT->PRESSED does.
- t_pulse registered, high for exactly one cycle, cleared on the following edge.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
- Unreachable state encodings return to IDLE with cnt=0, no pulse, q unchanged.

## Timing
- Reset (rst=1 at an edge): s1=s2=0, state=IDLE, cnt=0, button_level=0, t_pulse=0, q=0, q_n=1.
- Press latency: button_raw high before edge k and held -> s2=1 after k+1 -> PRESS_WAIT at k+2 -> t_pulse and q flip registered at edge k+2+DEBOUNCE_CYCLES (k+6 at default).
- button_level rises on the same edge as t_pulse; falls on the edge entering IDLE from RELEASE_WAIT (k'+2+DEBOUNCE_CYCLES after release sampled at k').
- Minimum accepted press: DEBOUNCE_CYCLES+1 consecutive high s2 samples; shorter glitches are ignored.
- Reset mid-PRESS_WAIT: press aborted, no pulse, q=0. Reset wins over any simultaneous transition.
- Button held high through reset deassertion: treated as a new press; one pulse after 2+DEBOUNCE_CYCLES cycles.
- Maximum pulse rate: one per 2*(DEBOUNCE_CYCLES+1) cycles.

## Structure
- Shared package pb_debounce_pkg: state encoding constants (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3) and DEBOUNCE_CYCLES legality check.
- Sub-module sync2 (two-flop synchroniser, reset to 0); reused by other input conditioners.
- FSM, counter and toggle register in the top module.

## Test plan
- Reset: rst=1 two cycles with button_raw=1 -> q=0, q_n=1, t_pulse=0, button_level=0; after release, exactly one pulse at 2+4 cycles.
- Clean press, default N=4: raw high at edge 10, held 20 cycles -> single t_pulse registered at edge 16, q 0->1, no pulse on release; second clean press -> q 1->0.
- Bounce rejection: raw 1,0,1,0,1 toggling each cycle then stable high -> no pulse during bounce; one pulse exactly 2+4 cycles after last rising sample.
- Release bounce: while PRESSED, raw 0 for 2 cycles then 1 -> returns to PRESSED, no pulse, button_level stays 1, q unchanged.
- Reset mid-PRESS_WAIT: rst=1 at edge k+4 of a press -> no pulse, q=0, state IDLE.
- DEBOUNCE_CYCLES=1: raw high at edge k -> pulse at k+3; pulses never longer than one cycle; q_n==~q every cycle (assertion).
